sys_csr_file: RTL and testbench

Machine-mode control/status register file. It answers CSR access requests issued by the system functional unit: read, write, set or clear one register, returning the pre-write value. It sits beside the execute stage and also owns the free-running cycle and retired-instruction counters. Requests and responses each use a valid/ready handshake; at most one request is in flight.

---
 rtl/sys_csr_file.sv | 170 +++++++++++++++++
 tb/tb_sys_csr_file.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_csr_file.sv
// sys_csr_file: machine-mode CSR file with 64-bit mcycle/minstret counters.
// Serves one read/write/set/clear request at a time through IDLE -> EXEC -> RESP.
module sys_csr_file #(
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned HART_ID    = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [1:0]            i_req_op,
  input  logic [11:0]           i_req_addr,
  input  logic                  i_req_wen,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic [DATA_WIDTH-1:0] o_resp_rdata,
  output logic                  o_resp_illegal,
  input  logic                  i_retire
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [1:0] OP_RW = 2'b00;
  localparam logic [1:0] OP_RS = 2'b01;
  localparam logic [1:0] OP_RC = 2'b10;
  localparam logic [1:0] OP_RO = 2'b11;
  localparam logic [DATA_WIDTH-1:0] HART_VAL = DATA_WIDTH'(HART_ID);

  state_t                r_state;
  logic [1:0]            r_op;
  logic [11:0]           r_addr;
  logic                  r_wen;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_mtvec;
  logic [DATA_WIDTH-1:0] r_mscratch;
  logic [DATA_WIDTH-1:0] r_mepc;
  logic [DATA_WIDTH-1:0] r_mcause;
  logic [63:0]           r_mcycle;
  logic [63:0]           r_minstret;
  logic                  r_resp_valid;
  logic                  r_resp_illegal;
  logic [DATA_WIDTH-1:0] r_resp_rdata;

  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_new;
  logic                  w_mapped;
  logic                  w_do_write;
  logic                  w_illegal;
  logic                  w_commit;
  logic [63:0]           w_mcycle_inc;
  logic [63:0]           w_mcycle_next;
  logic [63:0]           w_minstret_inc;
  logic [63:0]           w_minstret_next;

  // Read mux over the latched address; user-level counter names alias the machine ones.
  always_comb begin
    w_old    = '0;
    w_mapped = 1'b1;
    case (r_addr)
      12'h305:          w_old = r_mtvec;
      12'h340:          w_old = r_mscratch;
      12'h341:          w_old = r_mepc;
      12'h342:          w_old = r_mcause;
      12'hB00, 12'hC00: w_old = r_mcycle[31:0];
      12'hB80, 12'hC80: w_old = r_mcycle[63:32];
      12'hB02, 12'hC02: w_old = r_minstret[31:0];
      12'hB82, 12'hC82: w_old = r_minstret[63:32];
      12'hF14:          w_old = HART_VAL;
      default:          w_mapped = 1'b0;
    endcase
  end

  assign w_do_write = r_wen && (r_op != OP_RO);
  assign w_illegal  = !w_mapped || (w_do_write && (r_addr[11:10] == 2'b11));
  assign w_commit   = (r_state == S_EXEC) && w_do_write && !w_illegal;

  always_comb begin
    case (r_op)
      OP_RS:   w_new = w_old | r_wdata;
      OP_RC:   w_new = w_old & ~r_wdata;
      default: w_new = r_wdata;
    endcase
  end

  // A written half takes the written value; a low-half write also suppresses the carry.
  always_comb begin
    w_mcycle_inc    = r_mcycle + 64'd1;
    w_minstret_inc  = r_minstret + {63'd0, i_retire};
    w_mcycle_next   = w_mcycle_inc;
    w_minstret_next = w_minstret_inc;
    if (w_commit) begin
      case (r_addr)
        12'hB00: w_mcycle_next   = {r_mcycle[63:32], w_new};
        12'hB80: w_mcycle_next   = {w_new, w_mcycle_inc[31:0]};
        12'hB02: w_minstret_next = {r_minstret[63:32], w_new};
        12'hB82: w_minstret_next = {w_new, w_minstret_inc[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      r_mcycle   <= w_mcycle_next;
      r_minstret <= w_minstret_next;
      if (w_commit) begin
        case (r_addr)
          12'h305: r_mtvec    <= {w_new[DATA_WIDTH-1:2], 2'b00};
          12'h340: r_mscratch <= w_new;
          12'h341: r_mepc     <= {w_new[DATA_WIDTH-1:2], 2'b00};
          12'h342: r_mcause   <= w_new;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_op           <= OP_RO;
      r_addr         <= '0;
      r_wen          <= 1'b0;
      r_wdata        <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_rdata   <= '0;
      r_resp_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_op    <= i_req_op;
            r_addr  <= i_req_addr;
            r_wen   <= i_req_wen;
            r_wdata <= i_req_wdata;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_resp_rdata   <= w_illegal ? '0 : w_old;
          r_resp_illegal <= w_illegal;
          r_resp_valid   <= 1'b1;
          r_state        <= S_RESP;
        end
        S_RESP: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gated by reset so the block reads busy while reset is held and ready right after.
  assign o_req_ready    = (r_state == S_IDLE) && i_rst_n;
  assign o_resp_valid   = r_resp_valid;
  assign o_resp_rdata   = r_resp_rdata;
  assign o_resp_illegal = r_resp_illegal;

endmodule

// File: tb/tb_sys_csr_file.sv
// tb_sys_csr_file: scoreboard bench for sys_csr_file; a behavioural CSR/counter model
// predicts each response, and an independent monitor compares what the DUT presents.
module tb_sys_csr_file;

  localparam int unsigned HART = 32'h0000_0005;
  localparam int          MAXC = 20000;
  localparam logic [1:0]  RW = 2'b00, RS = 2'b01, RC = 2'b10, RO = 2'b11;

  typedef struct packed {
    logic [31:0] rdata;
    logic        illegal;
  } resp_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid;
  logic        reqReady;
  logic [1:0]  reqOp;
  logic [11:0] reqAddr;
  logic        reqWen;
  logic [31:0] reqWdata;
  logic        respValid;
  logic        respReady;
  logic [31:0] respRdata;
  logic        respIllegal;
  logic        iRetire;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hsCycle = -10;
  int respHold = 0;
  int retireReq = 0;
  bit randomRetire = 0;
  bit forceRetire = 0;
  bit retireLog [MAXC];
  int lastAccept;
  bit acceptOk;
  resp_t sbq [$];

  logic [31:0]     mTvec, mScratch, mEpc, mCause;
  longint unsigned cycBase, insBase;
  int              cycBaseCycle, insBaseCycle;

  sys_csr_file #(.DATA_WIDTH(32), .HART_ID(HART)) dut (
    .i_clk(clk), .i_rst_n(rstN),
    .i_req_valid(reqValid), .o_req_ready(reqReady), .i_req_op(reqOp),
    .i_req_addr(reqAddr), .i_req_wen(reqWen), .i_req_wdata(reqWdata),
    .o_resp_valid(respValid), .i_resp_ready(respReady),
    .o_resp_rdata(respRdata), .o_resp_illegal(respIllegal),
    .i_retire(iRetire)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Counter values are derived from the last written base plus elapsed cycles / logged retires.
  function automatic longint unsigned modelCycle(input int n);
    return cycBase + 64'(n - cycBaseCycle);
  endfunction

  function automatic longint unsigned modelInstret(input int n);
    longint unsigned sum = insBase;
    for (int i = insBaseCycle; i < n && i < MAXC; i++) sum += 64'(retireLog[i]);
    return sum;
  endfunction

  function automatic void modelRead(input logic [11:0] addr, input int n,
                                    output logic [31:0] v, output bit mapped);
    longint unsigned c = modelCycle(n);
    longint unsigned r = modelInstret(n);
    mapped = 1;
    v = 32'd0;
    case (addr)
      12'h305: v = mTvec;
      12'h340: v = mScratch;
      12'h341: v = mEpc;
      12'h342: v = mCause;
      12'hB00, 12'hC00: v = c[31:0];
      12'hB80, 12'hC80: v = c[63:32];
      12'hB02, 12'hC02: v = r[31:0];
      12'hB82, 12'hC82: v = r[63:32];
      12'hF14: v = HART;
      default: mapped = 0;
    endcase
  endfunction

  task automatic modelWrite(input logic [11:0] addr, input logic [31:0] val, input int e);
    longint unsigned v;
    case (addr)
      12'h305: mTvec = val & ~32'h3;
      12'h340: mScratch = val;
      12'h341: mEpc = val & ~32'h3;
      12'h342: mCause = val;
      12'hB00: begin v = modelCycle(e); cycBase = {v[63:32], val}; cycBaseCycle = e + 1; end
      12'hB80: begin v = modelCycle(e) + 1; cycBase = {val, v[31:0]}; cycBaseCycle = e + 1; end
      12'hB02: begin v = modelInstret(e); insBase = {v[63:32], val}; insBaseCycle = e + 1; end
      12'hB82: begin
        v = modelInstret(e) + 64'(retireLog[e]);
        insBase = {val, v[31:0]};
        insBaseCycle = e + 1;
      end
      default: ;
    endcase
  endtask

  task automatic modelReset();
    mTvec = 0; mScratch = 0; mEpc = 0; mCause = 0;
    cycBase = 0; cycBaseCycle = cyc;
    insBase = 0; insBaseCycle = cyc;
    sbq.delete();
    hsCycle = -10;
  endtask

  task automatic doReset();
    rstN = 0;
    reqValid = 0;
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", reqReady, 0);
    checkOutput("rst_resp_valid", respValid, 0);
    checkOutput("rst_resp_rdata", respRdata, 0);
    checkOutput("rst_resp_illegal", respIllegal, 0);
    rstN = 1;
    modelReset();
    @(negedge clk);
    checkOutput("ready_after_reset", reqReady, 1);
  endtask

  // Returns at the falling edge inside the EXEC cycle of the accepted request.
  task automatic acceptRequest(input logic [1:0] op, input logic [11:0] addr,
                               input logic wen, input logic [31:0] wdata);
    acceptOk = 0;
    reqOp = op; reqAddr = addr; reqWen = wen; reqWdata = wdata;
    reqValid = 1;
    for (int i = 0; i < 50; i++) begin
      if (reqReady) begin
        lastAccept = cyc;
        acceptOk = 1;
        break;
      end
      @(negedge clk);
    end
    if (!acceptOk) begin
      checkOutput("accept_timeout", reqReady, 1);
      reqValid = 0;
      return;
    end
    @(negedge clk);
    reqValid = 0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 100 && sbq.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sbq.size() != 0) begin
      checkOutput("resp_timeout", 64'(sbq.size()), 0);
      sbq.delete();
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [11:0] addr,
                               input logic wen, input logic [31:0] wdata);
    logic [31:0] old, newVal;
    bit mapped, doWrite, illegal;
    resp_t exp;
    int e;
    acceptRequest(op, addr, wen, wdata);
    if (!acceptOk) return;
    e = lastAccept + 1;
    checkOutput("resp_not_early", respValid, 0);
    modelRead(addr, e, old, mapped);
    doWrite = wen && (op != RO);
    illegal = !mapped || (doWrite && addr[11:10] == 2'b11);
    exp.rdata = illegal ? 32'd0 : old;
    exp.illegal = illegal;
    sbq.push_back(exp);
    case (op)
      RS: newVal = old | wdata;
      RC: newVal = old & ~wdata;
      default: newVal = wdata;
    endcase
    @(negedge clk);
    checkOutput("resp_latency", respValid, 1);
    if (doWrite && !illegal) modelWrite(addr, newVal, e);
    waitDrain();
  endtask

  initial begin
    iRetire = 0;
    forever begin
      @(negedge clk);
      if (forceRetire) iRetire = 1;
      else if (retireReq > 0) begin
        iRetire = 1;
        retireReq--;
      end else iRetire = randomRetire ? 1'($urandom_range(0, 1)) : 1'b0;
      if (cyc < MAXC) retireLog[cyc] = iRetire;
    end
  end

  // Monitor: compares every cycle a response is presented, so stalls also prove stability.
  initial begin
    resp_t exp;
    respReady = 0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        respReady = 0;
        continue;
      end
      if (cyc == hsCycle + 1) checkOutput("ready_after_hs", reqReady, 1);
      if (respValid) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_resp", respValid, 0);
          respReady = 1;
        end else begin
          exp = sbq[0];
          checkOutput("resp_rdata", respRdata, exp.rdata);
          checkOutput("resp_illegal", respIllegal, exp.illegal);
          checkOutput("req_ready_busy", reqReady, 0);
          if (respHold > 0) begin
            respHold--;
            respReady = 0;
          end else respReady = ($urandom_range(0, 3) != 0);
          if (respReady) begin
            void'(sbq.pop_front());
            hsCycle = cyc;
          end
        end
      end else respReady = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [11:0] addrList [13];
    logic [11:0] a;
    int stallHs;
    addrList = '{12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80, 12'hB02,
                 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14};
    reqValid = 0; reqOp = RO; reqAddr = 0; reqWen = 0; reqWdata = 0; rstN = 0;
    doReset();

    applyStimulus(RW, 12'h340, 1, 32'hDEAD_BEEF);
    applyStimulus(RO, 12'h340, 0, 32'h0);
    applyStimulus(RW, 12'h340, 1, 32'h0000_000F);
    applyStimulus(RS, 12'h340, 1, 32'h0000_00F0);
    applyStimulus(RO, 12'h340, 0, 32'h0);
    applyStimulus(RC, 12'h340, 1, 32'h0000_000F);
    applyStimulus(RO, 12'h340, 0, 32'h0);
    applyStimulus(RS, 12'h340, 0, 32'hFFFF_FFFF);
    applyStimulus(RO, 12'h340, 0, 32'h0);
    applyStimulus(RW, 12'h305, 1, 32'h8000_0003);
    applyStimulus(RO, 12'h305, 0, 32'h0);
    applyStimulus(RW, 12'h341, 1, 32'h1234_5677);
    applyStimulus(RW, 12'h342, 1, 32'h8000_000B);
    applyStimulus(RO, 12'h342, 0, 32'h0);
    applyStimulus(RW, 12'hC00, 1, 32'h0000_0000);
    applyStimulus(RO, 12'hB00, 0, 32'h0);
    applyStimulus(RO, 12'h123, 0, 32'h0);
    applyStimulus(RO, 12'hF14, 0, 32'h0);
    applyStimulus(RW, 12'hF14, 1, 32'h1);
    applyStimulus(RS, 12'hC80, 0, 32'hFFFF_FFFF);

    respHold = 5;
    applyStimulus(RO, 12'h340, 0, 32'h0);
    stallHs = hsCycle;
    applyStimulus(RO, 12'h341, 0, 32'h0);
    checkOutput("accept_after_release", 64'(lastAccept), 64'(stallHs + 1));

    applyStimulus(RW, 12'hB80, 1, 32'h0);
    applyStimulus(RW, 12'hB00, 1, 32'hFFFF_FFFF);
    applyStimulus(RO, 12'hB80, 0, 32'h0);
    applyStimulus(RO, 12'hC80, 0, 32'h0);

    retireReq = 3;
    repeat (6) @(negedge clk);
    applyStimulus(RO, 12'hB02, 0, 32'h0);
    applyStimulus(RO, 12'hC02, 0, 32'h0);
    forceRetire = 1;
    applyStimulus(RW, 12'hB02, 1, 32'd10);
    forceRetire = 0;
    applyStimulus(RO, 12'hB02, 0, 32'h0);
    applyStimulus(RW, 12'hB82, 1, 32'h0000_0007);
    applyStimulus(RO, 12'hC82, 0, 32'h0);

    acceptRequest(RW, 12'h340, 1, 32'h0000_0055);
    doReset();
    repeat (3) @(negedge clk);
    applyStimulus(RO, 12'h340, 0, 32'h0);

    randomRetire = 1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0) a = 12'($urandom);
      else a = addrList[$urandom_range(0, 12)];
      applyStimulus(2'($urandom_range(0, 3)), a, ($urandom_range(0, 3) != 0), $urandom);
    end

    waitDrain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
